alu_issue_wb: RTL and testbench

//  Decode/issue + writeback stage wrapped around the ALU. Accepts one 16-bit instruction
//  per valid/ready handshake and decodes it. Reads two operands from an internal register

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_issue_wb_if.sv | 41 ++++
 rtl/alu_regfile.sv | 38 +++
 rtl/alu_issue_wb.sv | 137 +++++++++++++
 tb/tb_alu_issue_wb.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue/writeback stage: operation types, the
// instruction field layout and the stage FSM states.
package alu_pkg;

  localparam int INSTR_W = 16;
  localparam int REG_AW  = 3;

  typedef enum logic [1:0] {
    OT_MOVE  = 2'b00,
    OT_ARITH = 2'b01,
    OT_LOGIC = 2'b10,
    OT_NOP   = 2'b11
  } ot_e;

  // Field order fixes the bit positions: [15:14] ot, [13:10] opcode,
  // [9:7] rd, [6:4] rs, [3:0] b2opcode.
  typedef struct packed {
    ot_e               ot;
    logic [3:0]        opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [3:0]        b2opcode;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB
  } state_e;

endpackage

// File: rtl/alu_issue_wb_if.sv
// Instruction handshake plus the operand/control/result bus between the
// issue stage and the ALU.
interface alu_issue_wb_if
  import alu_pkg::*;
#(
  parameter int DW = 16
);
  logic                instr_valid;
  logic [INSTR_W-1:0]  instr;
  logic                instr_ready;

  logic [DW-1:0]       op1;
  logic [DW-1:0]       op2;
  logic [REG_AW-1:0]   op1_regaddr;
  logic [15:0]         op2_regaddr;
  logic [3:0]          ALU_opcode;
  logic [3:0]          ALU_b2opcode;
  logic [1:0]          ALU_OT;

  logic [DW-1:0]       alu_result;
  logic [REG_AW-1:0]   alu_addr;
  logic                za;
  logic                zb;
  logic                eq;
  logic                gt;
  logic                lt;

  // Environment side: supplies instructions and the ALU's answers.
  modport master (
    output instr_valid, instr, alu_result, alu_addr, za, zb, eq, gt, lt,
    input  instr_ready, op1, op2, op1_regaddr, op2_regaddr,
           ALU_opcode, ALU_b2opcode, ALU_OT
  );

  // Stage side: consumes instructions and drives the ALU.
  modport slave (
    input  instr_valid, instr, alu_result, alu_addr, za, zb, eq, gt, lt,
    output instr_ready, op1, op2, op1_regaddr, op2_regaddr,
           ALU_opcode, ALU_b2opcode, ALU_OT
  );
endinterface

// File: rtl/alu_regfile.sv
// NREG x DW register file: two operand read ports, one debug read port and a
// single synchronous write port; cleared by reset.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREG = 8,
  parameter int DW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DW-1:0]     rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DW-1:0]     rdata_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DW-1:0]     dbg_data
);

  logic [DW-1:0] mem [NREG];

  // NOTE: the array must read back as zero after reset, so it is built from
  // resettable flops rather than an inferred RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a  = mem[raddr_a];
  assign rdata_b  = mem[raddr_b];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_wb.sv
// Decode/issue + writeback stage around the ALU: one instruction in flight,
// operands held for EXEC_CYCLES, result written back to R[alu_addr].
module alu_issue_wb
  import alu_pkg::*;
#(
  parameter int NREG        = 8,
  parameter int DW          = 16,
  parameter int EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_wb_if.slave     bus,
  output logic [4:0]        flags,
  output logic              wb_valid,
  output logic              busy,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DW-1:0]     dbg_data
);

  localparam int            CW        = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0] EXEC_LOAD = CW'(EXEC_CYCLES - 1);

  state_e            state_q, state_d;
  instr_t            instr_q;
  logic [CW-1:0]     exec_cnt;
  logic              accept, issue, wb_now, reg_we;
  logic [DW-1:0]     rd_data, rs_data;
  logic [DW-1:0]     op1_q, op2_q;
  logic [REG_AW-1:0] rd_q, rs_q;
  logic [3:0]        opc_q, b2_q;
  ot_e               ot_q;

  // NOTE: every flop uses <= so all processes see the pre-edge values and
  // the result does not depend on process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: defaults come first so no path through the case leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    wb_now  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid) begin
          accept  = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        issue   = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_cnt == '0) state_d = ST_WB;
      end
      ST_WB: begin
        wb_now  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ALU drive registers only change in DECODE, so they stay put through EXEC
  // and WB; OT falls back to the idle/zero path once writeback is done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q  <= '0;
      exec_cnt <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      opc_q    <= '0;
      b2_q     <= '0;
      ot_q     <= OT_NOP;
      flags    <= '0;
    end else begin
      if (accept) instr_q <= instr_t'(bus.instr);

      if (issue) begin
        op1_q    <= rd_data;
        op2_q    <= rs_data;
        rd_q     <= instr_q.rd;
        rs_q     <= instr_q.rs;
        opc_q    <= instr_q.opcode;
        b2_q     <= instr_q.b2opcode;
        ot_q     <= instr_q.ot;
        exec_cnt <= EXEC_LOAD;
      end else if (state_q == ST_EXEC && exec_cnt != '0) begin
        exec_cnt <= exec_cnt - CW'(1);
      end

      if (wb_now) begin
        if (ot_q == OT_LOGIC) flags <= {bus.za, bus.zb, bus.eq, bus.gt, bus.lt};
        ot_q <= OT_NOP;
      end
    end
  end

  assign reg_we   = wb_now && (ot_q != OT_NOP);
  assign wb_valid = reg_we;
  assign busy     = (state_q != ST_IDLE);

  assign bus.instr_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.op1          = op1_q;
  assign bus.op2          = op2_q;
  assign bus.op1_regaddr  = rd_q;
  assign bus.op2_regaddr  = {{(16 - REG_AW){1'b0}}, rs_q};
  assign bus.ALU_opcode   = opc_q;
  assign bus.ALU_b2opcode = b2_q;
  assign bus.ALU_OT       = ot_q;

  // The write target comes from the ALU, not rd: moves may redirect it.
  alu_regfile #(
    .NREG (NREG),
    .DW   (DW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (reg_we),
    .waddr    (bus.alu_addr),
    .wdata    (bus.alu_result),
    .raddr_a  (instr_q.rd),
    .rdata_a  (rd_data),
    .raddr_b  (instr_q.rs),
    .rdata_b  (rs_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

endmodule

// File: tb/tb_alu_issue_wb.sv
// Self-checking bench for alu_issue_wb: transaction-level reference model with
// per-cycle comparison, directed scenarios and randomized traffic.
module tb_alu_issue_wb;
  import alu_pkg::*;

  localparam int DW = 16;
  localparam int E  = 1;
  localparam int E3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_wb_if #(.DW(DW)) bus ();
  alu_issue_wb_if #(.DW(DW)) bus3 ();

  logic [4:0]    flags, flags3;
  logic          wb_valid, busy, wb_valid3, busy3;
  logic [2:0]    dbg_addr, dbg_addr3;
  logic [DW-1:0] dbg_data, dbg_data3;

  alu_issue_wb #(.NREG(8), .DW(DW), .EXEC_CYCLES(E)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .flags(flags), .wb_valid(wb_valid),
    .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  alu_issue_wb #(.NREG(8), .DW(DW), .EXEC_CYCLES(E3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .flags(flags3), .wb_valid(wb_valid3),
    .busy(busy3), .dbg_addr(dbg_addr3), .dbg_data(dbg_data3)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;
  int cyc = 0;
  int acc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(logic [1:0] ot, logic [3:0] opc, logic [2:0] rd,
                                     logic [2:0] rs, logic [3:0] b2);
    return {ot, opc, rd, rs, b2};
  endfunction

  // ---------------- reference model (transaction level) ----------------
  // An accepted instruction occupies the stage for 3+E cycles: its operands
  // appear on the ALU bus one edge after acceptance, writeback happens at
  // edge 2+E after acceptance, and wb_valid is high in the cycle before it.
  logic [DW-1:0] m_r [8];
  logic [4:0]    m_flags;
  bit            m_busy;
  int            m_k;
  instr_t        m_ins;
  logic [DW-1:0] m_acc1, m_acc2;
  logic [DW-1:0] m_op1, m_op2;
  logic [2:0]    m_a1, m_a2;
  logic [3:0]    m_opc, m_b2;
  logic [1:0]    m_ot;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_r[i] = '0;
      m_flags = '0; m_busy = 0; m_k = 0; m_ins = '0;
      m_op1 = '0; m_op2 = '0; m_a1 = '0; m_a2 = '0; m_opc = '0; m_b2 = '0;
      m_ot = 2'b11;
    end else if (m_busy) begin
      m_k++;
      if (m_k == 1) begin
        m_op1 = m_acc1; m_op2 = m_acc2; m_a1 = m_ins.rd; m_a2 = m_ins.rs;
        m_opc = m_ins.opcode; m_b2 = m_ins.b2opcode; m_ot = m_ins.ot;
      end
      if (m_k == 2 + E) begin
        if (m_ins.ot != OT_NOP) m_r[bus.alu_addr] = bus.alu_result;
        if (m_ins.ot == OT_LOGIC) m_flags = {bus.za, bus.zb, bus.eq, bus.gt, bus.lt};
        m_ot = 2'b11;
        m_busy = 0;
      end
    end else if (bus.instr_valid) begin
      m_busy = 1; m_k = 0;
      m_ins  = instr_t'(bus.instr);
      m_acc1 = m_r[m_ins.rd];
      m_acc2 = m_r[m_ins.rs];
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst && bus.instr_valid && bus.instr_ready) acc_q.push_back(cyc);
  end

  logic exp_wb;
  always @(negedge clk) begin
    if (cmp_on) begin
      exp_wb = m_busy && (m_k == 1 + E) && (m_ins.ot != OT_NOP);
      check("instr_ready", bus.instr_ready, !m_busy && !rst);
      check("busy", busy, m_busy);
      check("wb_valid", wb_valid, exp_wb);
      check("flags", flags, m_flags);
      check("op1", bus.op1, m_op1);
      check("op2", bus.op2, m_op2);
      check("op1_regaddr", bus.op1_regaddr, m_a1);
      check("op2_regaddr", bus.op2_regaddr, {13'b0, m_a2});
      check("ALU_opcode", bus.ALU_opcode, m_opc);
      check("ALU_b2opcode", bus.ALU_b2opcode, m_b2);
      check("ALU_OT", bus.ALU_OT, m_ot);
      check("dbg_data", dbg_data, m_r[dbg_addr]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!bus.instr_ready && g < 50) begin nxt(); g++; end
    if (g >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_ready: got timeout expected instr_ready");
    end
  endtask

  // Issues one instruction; lat counts the accept cycle as 1.
  task automatic issue(input logic [15:0] ins, input logic [DW-1:0] res, input logic [2:0] addr,
                       input logic [4:0] fl, output int wb_lat, output int done_lat);
    int lat;
    wait_ready();
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    bus.alu_result  = res;
    bus.alu_addr    = addr;
    {bus.za, bus.zb, bus.eq, bus.gt, bus.lt} = fl;
    nxt();
    bus.instr_valid = 1'b0;
    bus.instr       = 16'($urandom);
    lat    = 2;
    wb_lat = 0;
    while (lat < 50) begin
      if (wb_valid) wb_lat = lat;
      if (!busy) break;
      nxt();
      lat++;
    end
    done_lat = lat - 1;
  endtask

  initial begin
    #2_000_000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int wl, dl, base, idx, g;
    logic [15:0] b2b [3];

    bus.instr_valid = 0; bus.instr = '0; bus.alu_result = '0; bus.alu_addr = '0;
    {bus.za, bus.zb, bus.eq, bus.gt, bus.lt} = '0;
    bus3.instr_valid = 0; bus3.instr = '0; bus3.alu_result = '0; bus3.alu_addr = '0;
    {bus3.za, bus3.zb, bus3.eq, bus3.gt, bus3.lt} = '0;
    dbg_addr = '0; dbg_addr3 = '0;

    nxt();
    cmp_on = 1'b1;
    check("rst_ALU_OT", bus.ALU_OT, 2'b11);
    check("rst_ready", bus.instr_ready, 1'b0);
    nxt();
    rst = 1'b0;
    #1 check("ready_after_rst", bus.instr_ready, 1'b1);

    // Preload R1=5, R2=3 by moves, then add into R1.
    issue(mk(OT_MOVE, 4'h0, 3'd1, 3'd0, 4'h0), 16'h0005, 3'd1, 5'b0, wl, dl);
    issue(mk(OT_MOVE, 4'h0, 3'd2, 3'd0, 4'h0), 16'h0003, 3'd2, 5'b0, wl, dl);
    issue(mk(OT_ARITH, 4'h3, 3'd1, 3'd2, 4'h1), 16'h0008, 3'd1, 5'b0, wl, dl);
    check("t2_wb_lat", wl, 3 + E);
    check("t2_op1", bus.op1, 16'h0005);
    check("t2_op2", bus.op2, 16'h0003);
    dbg_addr = 3'd1;
    #1 check("t2_r1", dbg_data, 16'h0008);

    // Move redirected to R6 while rd=2.
    issue(mk(OT_MOVE, 4'h0, 3'd2, 3'd2, 4'h0), 16'h1234, 3'd6, 5'b0, wl, dl);
    dbg_addr = 3'd6;
    #1 check("t6_r6", dbg_data, 16'h1234);
    dbg_addr = 3'd2;
    #1 check("t6_r2", dbg_data, 16'h0003);

    // Flags latch only on OT=10.
    issue(mk(OT_LOGIC, 4'h5, 3'd7, 3'd1, 4'h2), 16'h00F0, 3'd7, 5'b00100, wl, dl);
    check("t3_flags", flags, 5'b00100);
    issue(mk(OT_ARITH, 4'h1, 3'd3, 3'd1, 4'h0), 16'h0042, 3'd3, 5'b11011, wl, dl);
    check("t3_flags_kept", flags, 5'b00100);

    // NOP walks the FSM without side effects.
    issue(mk(OT_NOP, 4'hF, 3'd1, 3'd1, 4'hF), 16'hFFFF, 3'd1, 5'b11111, wl, dl);
    check("t4_no_wb", wl, 0);
    check("t4_done_lat", dl, 3 + E);
    dbg_addr = 3'd1;
    #1 check("t4_r1", dbg_data, 16'h0008);
    check("t4_flags", flags, 5'b00100);

    // Reset in EXEC: abort, no writeback, flags and registers cleared.
    wait_ready();
    bus.instr_valid = 1'b1;
    bus.instr = mk(OT_LOGIC, 4'h2, 3'd4, 3'd1, 4'h0);
    bus.alu_result = 16'hBEEF; bus.alu_addr = 3'd4;
    nxt();
    bus.instr_valid = 1'b0;
    nxt();
    #1 rst = 1'b1;
    #1;
    check("t1_busy", busy, 1'b0);
    check("t1_flags", flags, 5'b0);
    check("t1_wb", wb_valid, 1'b0);
    check("t1_ALU_OT", bus.ALU_OT, 2'b11);
    nxt();
    nxt();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1 check("t1_reg_zero", dbg_data, 16'h0);
      nxt();
    end

    // Three back-to-back instructions with instr_valid held high.
    b2b[0] = mk(OT_MOVE, 4'h0, 3'd3, 3'd0, 4'h0);
    b2b[1] = mk(OT_ARITH, 4'h4, 3'd3, 3'd3, 4'h6);
    b2b[2] = mk(OT_LOGIC, 4'h7, 3'd5, 3'd3, 4'h9);
    bus.alu_result = 16'h1111; bus.alu_addr = 3'd3;
    {bus.za, bus.zb, bus.eq, bus.gt, bus.lt} = 5'b01010;
    wait_ready();
    base = acc_q.size();
    idx = 0; g = 0;
    bus.instr_valid = 1'b1;
    bus.instr = b2b[0];
    while (idx < 3 && g < 60) begin
      nxt(); g++;
      if (acc_q.size() - base > idx) begin
        idx++;
        if (idx == 3) bus.instr_valid = 1'b0;
        else          bus.instr = b2b[idx];
      end
    end
    repeat (8) nxt();
    check("t5_accepts", acc_q.size() - base, 3);
    if (acc_q.size() - base >= 3) begin
      check("t5_gap1", acc_q[base + 1] - acc_q[base], 3 + E);
      check("t5_gap2", acc_q[base + 2] - acc_q[base + 1], 3 + E);
    end
    check("t5_flags", flags, 5'b01010);

    // Randomized traffic with one asynchronous reset pulse in the middle.
    for (int n = 0; n < 800; n++) begin
      bus.instr_valid = ($urandom_range(0, 2) != 0);
      bus.instr       = 16'($urandom);
      bus.alu_result  = 16'($urandom);
      bus.alu_addr    = 3'($urandom);
      {bus.za, bus.zb, bus.eq, bus.gt, bus.lt} = 5'($urandom);
      dbg_addr        = 3'($urandom);
      if (n == 400) begin
        #1 rst = 1'b1;
        nxt();
        rst = 1'b0;
      end else begin
        nxt();
      end
    end
    bus.instr_valid = 1'b0;
    repeat (8) nxt();

    // EXEC_CYCLES=3 instance: latency 6 and stable ALU drive during EXEC.
    bus3.instr_valid = 1'b1;
    bus3.instr = mk(OT_MOVE, 4'h9, 3'd2, 3'd3, 4'h5);
    bus3.alu_result = 16'hABCD; bus3.alu_addr = 3'd6;
    check("e3_ready", bus3.instr_ready, 1'b1);
    nxt();
    bus3.instr_valid = 1'b0;
    bus3.instr = 16'hFFFF;
    wl = 0;
    dl = 2;
    while (dl < 50) begin
      if (wb_valid3) wl = dl;
      if (dl >= 3 && dl <= 2 + E3) begin
        check("e3_opcode", bus3.ALU_opcode, 4'h9);
        check("e3_b2", bus3.ALU_b2opcode, 4'h5);
        check("e3_OT", bus3.ALU_OT, 2'b00);
        check("e3_rd", bus3.op1_regaddr, 3'd2);
        check("e3_rs", bus3.op2_regaddr, 16'd3);
      end
      if (!busy3) break;
      nxt();
      dl++;
    end
    check("e3_wb_lat", wl, 6);
    check("e3_done_lat", dl - 1, 6);
    dbg_addr3 = 3'd6;
    #1 check("e3_r6", dbg_data3, 16'hABCD);
    dbg_addr3 = 3'd2;
    #1 check("e3_r2", dbg_data3, 16'h0000);

    nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
